// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the digit-serial CLA subtractor.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_sub_state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice with carry-in.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure datapath.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat function of g/p/cin, so there is no ripple chain.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Digit-serial a - b (as a + ~b + 1), one 4-bit CLA slice per clock; CLA_SUB_FLAGS_EN adds zero/neg/ovf flags.
// Latency: operands accepted at edge k, out_valid high after edge k + WIDTH/4.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready is sampled high.
module cla_serial_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
`ifdef CLA_SUB_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    cla_sub_state_t   state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] nb_reg;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] sum_nib;
    logic               cout;

    assign a_nib    = a_reg[idx*SLICE_W +: SLICE_W];
    assign b_nib    = nb_reg[idx*SLICE_W +: SLICE_W];
    assign in_ready = (state == IDLE);

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (sum_nib),
        .cout (cout)
    );

`ifdef CLA_SUB_FLAGS_EN
    // Full result as it will look after this edge, so flags can be registered with the last nibble.
    logic [WIDTH-1:0] final_diff;
    always_comb begin
        final_diff = out_diff;
        final_diff[idx*SLICE_W +: SLICE_W] = sum_nib;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            carry      <= 1'b1;
            a_reg      <= '0;
            nb_reg     <= '0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
            out_valid  <= 1'b0;
`ifdef CLA_SUB_FLAGS_EN
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= in_a;
                        nb_reg <= ~in_b;
                        idx    <= '0;
                        carry  <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    out_diff[idx*SLICE_W +: SLICE_W] <= sum_nib;
                    carry <= cout;
                    if (idx == LAST_IDX) begin
                        out_borrow <= ~cout;
                        out_valid  <= 1'b1;
                        state      <= DONE;
`ifdef CLA_SUB_FLAGS_EN
                        out_zero <= (final_diff == '0);
                        out_neg  <= final_diff[WIDTH-1];
                        // nb_reg holds ~b, so operand signs differ when the two MSBs match.
                        out_ovf  <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1])
                                  & (final_diff[WIDTH-1] != a_reg[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Randomized and directed check of cla_serial_subtractor against a plain-arithmetic reference.
module tb_cla_serial_subtractor;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
`ifdef CLA_SUB_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    cla_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow)
`ifdef CLA_SUB_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Full transaction: accept, measure latency, compare result, stall for hold cycles, release.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
        logic [WIDTH-1:0] exp_diff;
        int n;
        exp_diff = WIDTH'(a - b);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(NSLICE));
        check("diff", 32'(out_diff), 32'(exp_diff));
        check("borrow", 32'(out_borrow), 32'(a < b));
        check("busy_ready", 32'(in_ready), 32'd0);
`ifdef CLA_SUB_FLAGS_EN
        begin
            int sd;
            sd = int'($signed(a)) - int'($signed(b));
            check("zero", 32'(out_zero), 32'(exp_diff == '0));
            check("neg", 32'(out_neg), 32'(exp_diff[WIDTH-1]));
            check("ovf", 32'(out_ovf), 32'((sd > 32767) || (sd < -32768)));
        end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_diff", 32'(out_diff), 32'(exp_diff));
            check("hold_borrow", 32'(out_borrow), 32'(a < b));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_diff", 32'(out_diff), 32'd0);
        check("rst_borrow", 32'(out_borrow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0034, 0);
        run_op(16'h0100, 16'h0001, 1);
        run_op(16'h0000, 16'h0001, 0);
        run_op(16'h8000, 16'h0001, 2);
        run_op(16'hBEEF, 16'hBEEF, 0);
        run_op(16'h7FFF, 16'hFFFF, 0);
        run_op(16'hFFFF, 16'h0000, 5);

        // Reset while the third slice is about to be computed.
        in_a     = 16'hA5A5;
        in_b     = 16'h1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_diff", 32'(out_diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h5000, 16'h0FFF, 1);

        for (int i = 0; i < 40; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
